// File: rtl/ram_rd_pkg.sv
// Shared types and constants for the data-RAM stream reader.
package ram_rd_pkg;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 32;
    localparam int CNT_W      = 12;
    localparam int WORD_BYTES = 4;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN
    } state_t;

endpackage

// File: rtl/stream_fifo2.sv
// Two-entry FIFO of {data, last} between the RAM read port and the output stream.
module stream_fifo2 #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         push_last,
    input  logic         pop,
    output logic         can_push,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head_data,
    output logic         head_last
);

    logic [W-1:0] data_q [2];
    logic         last_q [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;

    // Caller only pushes when can_push is high and only pops when non-empty.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (push) wr_ptr <= ~wr_ptr;
            if (pop)  rd_ptr <= ~rd_ptr;
            count <= count + 2'(push) - 2'(pop);
        end
    end

    // NOTE: storage is not reset; the flushed count makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            data_q[wr_ptr] <= push_data;
            last_q[wr_ptr] <= push_last;
        end
    end

    assign full      = count[1];
    assign empty     = (count == 2'd0);
    assign can_push  = !full || pop;
    assign head_data = data_q[rd_ptr];
    assign head_last = last_q[rd_ptr];

endmodule

// File: rtl/ram_stream_reader.sv
// Walks N consecutive RAM words from a base address and streams them out with a last flag.
module ram_stream_reader #(
    parameter int DATA_W = ram_rd_pkg::DATA_W,
    parameter int ADDR_W = ram_rd_pkg::ADDR_W,
    parameter int CNT_W  = ram_rd_pkg::CNT_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [CNT_W-1:0]  word_count,
    output logic [ADDR_W-1:0] mem_A,
    input  logic [DATA_W-1:0] mem_RD,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic              done
);

    ram_rd_pkg::state_t state;
    logic [ADDR_W-1:0]  addr;
    logic [CNT_W-1:0]   remaining;
    logic               can_push;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push_fire;
    logic               pop_fire;
    logic               unused_low_bits;

    // Byte-offset bits of the base are dropped when the address is latched.
    assign unused_low_bits = ^base_addr[1:0];

    assign pop_fire  = out_valid && out_ready;
    assign push_fire = (state == ram_rd_pkg::READ) && can_push;
    assign out_valid = !fifo_empty;
    assign mem_A     = addr;

    stream_fifo2 #(.W(DATA_W)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_fire),
        .push_data (mem_RD),
        .push_last (remaining == CNT_W'(1)),
        .pop       (pop_fire),
        .can_push  (can_push),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head_data (out_data),
        .head_last (out_last)
    );

    // NOTE: all state here is sequential, so every update uses <= to avoid ordering races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ram_rd_pkg::IDLE;
            addr      <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ram_rd_pkg::IDLE: begin
                    if (start) begin
                        if (word_count != '0) begin
                            addr      <= {base_addr[ADDR_W-1:2], 2'b00};
                            remaining <= word_count;
                            busy      <= 1'b1;
                            state     <= ram_rd_pkg::READ;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ram_rd_pkg::READ: begin
                    if (push_fire) begin
                        addr      <= addr + ADDR_W'(ram_rd_pkg::WORD_BYTES);
                        remaining <= remaining - CNT_W'(1);
                        if (remaining == CNT_W'(1)) state <= ram_rd_pkg::DRAIN;
                    end
                end
                ram_rd_pkg::DRAIN: begin
                    // The last-flagged entry is always the final one left in the FIFO.
                    if (pop_fire && out_last) begin
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= ram_rd_pkg::IDLE;
                    end
                end
                default: state <= ram_rd_pkg::IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_stream_reader.sv
// Randomised self-checking bench for ram_stream_reader against an address-arithmetic model.
module tb_ram_stream_reader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] base_addr;
    logic [11:0] word_count;
    logic [31:0] mem_A;
    logic [31:0] mem_RD;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    logic [31:0] ram [4096];
    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    assign mem_RD = ram[mem_A[13:2]];

    ram_stream_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .base_addr  (base_addr),
        .word_count (word_count),
        .mem_A      (mem_A),
        .mem_RD     (mem_RD),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_last   (out_last),
        .busy       (busy),
        .done       (done)
    );

    // Expected word for transfer element i: RAM content at the wrapped byte address.
    function automatic logic [31:0] model_word(input logic [31:0] base_al, input int i);
        logic [31:0] a;
        a = base_al + 32'(4 * i);
        return 32'hA000_0000 + {20'd0, a[13:2]};
    endfunction

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // mode 0: ready always high, 1: ready 1,0,0 repeating, 2: random ready.
    task automatic run_xfer(input logic [31:0] base, input int count, input int mode,
                            input bit poke, input string tag);
        logic [31:0] base_al;
        logic [31:0] exp_word;
        logic [31:0] prev_data;
        logic        prev_last;
        bit          prev_stall;
        bit          fin;
        bit          ended;
        int          acc;
        int          fin_c;
        base_al    = {base[31:2], 2'b00};
        acc        = 0;
        fin        = 0;
        fin_c      = 0;
        ended      = 0;
        prev_stall = 0;
        prev_data  = '0;
        prev_last  = 0;
        start      = 1'b1;
        base_addr  = base;
        word_count = 12'(count);
        step();
        start      = 1'b0;
        base_addr  = $urandom;
        word_count = 12'($urandom);
        for (int c = 1; c <= count * 8 + 20 && !ended; c++) begin
            case (mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (c < 2) || ((c - 2) % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            start = poke && (c == 2);
            if (poke && c == 2) begin
                base_addr  = 32'h0000_0100;
                word_count = 12'd7;
            end
            if (c == 1) begin
                n_checks++;
                if (out_valid !== 1'b0 || mem_A !== base_al || busy !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s first_cycle: valid=%b mem_A=%h busy=%b, want valid=0 mem_A=%h busy=1",
                             tag, out_valid, mem_A, busy, base_al);
                end
            end
            if (c == 2) begin
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_errors++;
                    $display("FAIL %s first_valid: valid=%b, want 1", tag, out_valid);
                end
            end
            if (mode == 0 && c <= count) begin
                n_checks++;
                if (mem_A !== base_al + 32'(4 * (c - 1))) begin
                    n_errors++;
                    $display("FAIL %s addr_seq c=%0d: mem_A=%h, want %h", tag, c, mem_A,
                             base_al + 32'(4 * (c - 1)));
                end
            end
            if (!fin) begin
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b1 || ((mem_A - base_al) >> 2) > 32'(acc + 2)) begin
                    n_errors++;
                    $display("FAIL %s in_flight c=%0d: done=%b busy=%b mem_A=%h accepted=%0d",
                             tag, c, done, busy, mem_A, acc);
                end
            end
            if (prev_stall) begin
                n_checks++;
                if (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last) begin
                    n_errors++;
                    $display("FAIL %s stall_hold c=%0d: valid=%b data=%h last=%b, want 1 %h %b",
                             tag, c, out_valid, out_data, out_last, prev_data, prev_last);
                end
            end
            if (fin && c == fin_c + 1) begin
                n_checks++;
                if (done !== 1'b1 || out_valid !== 1'b0 || mem_A !== base_al + 32'(4 * count)) begin
                    n_errors++;
                    $display("FAIL %s done_pulse: done=%b valid=%b mem_A=%h, want 1 0 %h",
                             tag, done, out_valid, mem_A, base_al + 32'(4 * count));
                end
            end
            if (fin && c == fin_c + 2) begin
                n_checks++;
                if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                    n_errors++;
                    $display("FAIL %s after_done: done=%b busy=%b valid=%b, want 0 0 0",
                             tag, done, busy, out_valid);
                end
                ended = 1;
            end
            if (!fin && out_valid && out_ready) begin
                exp_word = model_word(base_al, acc);
                n_checks++;
                if (out_data !== exp_word || out_last !== (acc == count - 1)) begin
                    n_errors++;
                    $display("FAIL %s beat%0d: data=%h last=%b, want %h %b", tag, acc,
                             out_data, out_last, exp_word, acc == count - 1);
                end
                if (mode == 0) begin
                    n_checks++;
                    if (c != acc + 2) begin
                        n_errors++;
                        $display("FAIL %s beat%0d_timing: cycle=%0d, want %0d", tag, acc, c, acc + 2);
                    end
                end
                acc++;
                if (acc == count) begin
                    fin   = 1;
                    fin_c = c;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
            prev_last  = out_last;
            if (!ended) step();
        end
        start = 1'b0;
        if (!ended) begin
            n_errors++;
            $display("FAIL %s timeout: accepted=%0d of %0d, done not seen", tag, acc, count);
        end
    endtask

    task automatic test_reset;
        rst_n      = 1'b0;
        start      = 1'b0;
        out_ready  = 1'b0;
        base_addr  = '0;
        word_count = '0;
        step();
        step();
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || mem_A !== 32'h0 || out_last !== 1'b0) begin
            n_errors++;
            $display("FAIL reset: valid=%b busy=%b done=%b mem_A=%h last=%b, want all 0",
                     out_valid, busy, done, mem_A, out_last);
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_basic;
        run_xfer(32'h0000_0010, 3, 0, 0, "basic");
    endtask

    task automatic test_backpressure;
        run_xfer(32'h0000_0200, 4, 1, 0, "backpressure");
    endtask

    task automatic test_empty;
        logic [31:0] held_a;
        held_a     = mem_A;
        out_ready  = 1'b1;
        start      = 1'b1;
        base_addr  = 32'h0000_0400;
        word_count = 12'd0;
        step();
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0 || mem_A !== held_a) begin
            n_errors++;
            $display("FAIL empty_done: done=%b busy=%b valid=%b mem_A=%h, want 1 0 0 %h",
                     done, busy, out_valid, mem_A, held_a);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (done !== 1'b0 || busy !== 1'b0 || out_valid !== 1'b0) begin
                n_errors++;
                $display("FAIL empty_idle%0d: done=%b busy=%b valid=%b, want 0 0 0",
                         i, done, busy, out_valid);
            end
        end
    endtask

    task automatic test_wrap;
        run_xfer(32'hFFFF_FFF8, 3, 0, 0, "wrap");
    endtask

    task automatic test_mid_reset;
        out_ready  = 1'b1;
        start      = 1'b1;
        base_addr  = 32'h0000_0040;
        word_count = 12'd5;
        step();
        start = 1'b0;
        step();
        for (int c = 2; c <= 3; c++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_data !== 32'hA000_000E + 32'(c)) begin
                n_errors++;
                $display("FAIL midreset_beat%0d: valid=%b data=%h, want 1 %h",
                         c - 2, out_valid, out_data, 32'hA000_000E + 32'(c));
            end
            if (c == 3) rst_n = 1'b0;
            step();
        end
        rst_n = 1'b1;
        n_checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || mem_A !== 32'h0 || done !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_abort: valid=%b busy=%b mem_A=%h done=%b, want 0 0 0 0",
                     out_valid, busy, mem_A, done);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            n_checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
                n_errors++;
                $display("FAIL midreset_quiet%0d: valid=%b busy=%b done=%b, want 0 0 0",
                         i, out_valid, busy, done);
            end
        end
        run_xfer(32'h0000_0000, 1, 0, 0, "after_reset");
    endtask

    task automatic test_start_while_busy;
        run_xfer(32'h0000_0003, 4, 2, 1, "busy_start");
    endtask

    task automatic test_random;
        for (int t = 0; t < 8; t++) begin
            run_xfer($urandom, $urandom_range(1, 9), 2, 1'($urandom_range(0, 1)), "random");
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 32'hA000_0000 + 32'(i);
        test_reset();
        test_basic();
        test_backpressure();
        test_empty();
        test_wrap();
        test_mid_reset();
        test_start_while_busy();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
